// File: rtl/sram_arbiter.sv
// sram_arbiter: two-port arbiter/sequencer for a 64K x 16 asynchronous SRAM.
// Port 0 is the CPU, port 1 the link loader/DMA engine. Every access runs
// IDLE -> SETUP -> ACTIVE (1+WAIT_STATES cycles) -> RECOVER -> IDLE, and all
// SRAM pins come straight from registers.
// Build option: define SRAM_ARB_FIXED_PRIO_EN to give port 0 every tie;
// otherwise ties alternate round-robin.
module sram_arbiter #(
  parameter int unsigned WAIT_STATES = 1
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        p0_valid,
  input  logic [15:0] p0_addr,
  input  logic [15:0] p0_wdata,
  input  logic [1:0]  p0_wstrb,
  output logic        p0_ready,
  output logic [15:0] p0_rdata,
  input  logic        p1_valid,
  input  logic [15:0] p1_addr,
  input  logic [15:0] p1_wdata,
  input  logic [1:0]  p1_wstrb,
  output logic        p1_ready,
  output logic [15:0] p1_rdata,
  output logic [15:0] sram_a,
  output logic [15:0] sram_dout,
  output logic        sram_doe,
  input  logic [15:0] sram_din,
  output logic        sram_ce,
  output logic        sram_we,
  output logic        sram_oe,
  output logic        sram_lb,
  output logic        sram_ub
);

  localparam logic [2:0] ACT_LAST = 3'(WAIT_STATES);

  typedef enum logic [1:0] {IDLE, SETUP, ACTIVE, RECOVER} state_t;

  state_t      state;
  logic [2:0]  cnt;
  logic        gnt;
  logic        wr_q;
  logic        gnt_c;
  logic [15:0] sel_addr_c;
  logic [15:0] sel_wdata_c;
  logic [1:0]  sel_wstrb_c;

`ifndef SRAM_ARB_FIXED_PRIO_EN
  logic        last;
`endif

  // Grant decision for the current IDLE cycle and the selected request fields.
  always_comb begin
`ifdef SRAM_ARB_FIXED_PRIO_EN
    gnt_c = ~p0_valid;
`else
    if (p0_valid && p1_valid) gnt_c = ~last;
    else                      gnt_c = p1_valid;
`endif
    sel_addr_c  = gnt_c ? p1_addr  : p0_addr;
    sel_wdata_c = gnt_c ? p1_wdata : p0_wdata;
    sel_wstrb_c = gnt_c ? p1_wstrb : p0_wstrb;
  end

  // Access sequencer; the SRAM pin registers hold the latched request.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= IDLE;
      cnt       <= 3'd0;
      gnt       <= 1'b0;
      wr_q      <= 1'b0;
`ifndef SRAM_ARB_FIXED_PRIO_EN
      last      <= 1'b1;
`endif
      sram_ce   <= 1'b1;
      sram_we   <= 1'b1;
      sram_oe   <= 1'b1;
      sram_lb   <= 1'b1;
      sram_ub   <= 1'b1;
      sram_doe  <= 1'b0;
      sram_a    <= 16'd0;
      sram_dout <= 16'd0;
      p0_ready  <= 1'b0;
      p1_ready  <= 1'b0;
      p0_rdata  <= 16'd0;
      p1_rdata  <= 16'd0;
    end else begin
      p0_ready <= 1'b0;
      p1_ready <= 1'b0;
      case (state)
        IDLE: begin
          if (p0_valid || p1_valid) begin
            gnt     <= gnt_c;
`ifndef SRAM_ARB_FIXED_PRIO_EN
            last    <= gnt_c;
`endif
            wr_q    <= |sel_wstrb_c;
            sram_ce <= 1'b0;
            sram_a  <= sel_addr_c;
            if (|sel_wstrb_c) begin
              sram_lb   <= ~sel_wstrb_c[0];
              sram_ub   <= ~sel_wstrb_c[1];
              sram_dout <= sel_wdata_c;
              sram_doe  <= 1'b1;
            end else begin
              sram_lb <= 1'b0;
              sram_ub <= 1'b0;
            end
            state <= SETUP;
          end
        end
        SETUP: begin
          cnt <= 3'd0;
          if (wr_q) sram_we <= 1'b0;
          else      sram_oe <= 1'b0;
          state <= ACTIVE;
        end
        ACTIVE: begin
          if (cnt == ACT_LAST) begin
            sram_oe <= 1'b1;
            sram_we <= 1'b1;
            if (!wr_q) begin
              if (gnt) p1_rdata <= sram_din;
              else     p0_rdata <= sram_din;
            end
            p0_ready <= ~gnt;
            p1_ready <= gnt;
            state    <= RECOVER;
          end else begin
            cnt <= cnt + 3'd1;
          end
        end
        RECOVER: begin
          sram_ce  <= 1'b1;
          sram_lb  <= 1'b1;
          sram_ub  <= 1'b1;
          sram_doe <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
